// File: rtl/ahb_lite_decoder_tmo.sv
// AHB-Lite root decoder: region decode with write protection, a data-phase FSM
// producing the two-cycle ERROR response, and a stall watchdog that quarantines hung responders.
module ahb_lite_decoder_tmo #(
  parameter int AHB_LITE_ADDR_WIDTH = 32,
  parameter int AHB_LITE_DATA_WIDTH = 32,
  parameter int NUM_RESPONDERS      = 8,
  parameter int TIMEOUT_WIDTH       = 16
) (
  input  logic                                                    hclk,
  input  logic                                                    hreset,
  input  logic [AHB_LITE_ADDR_WIDTH-1:0]                          haddr_i,
  input  logic [AHB_LITE_DATA_WIDTH-1:0]                          hwdata_i,
  input  logic                                                    hwrite_i,
  input  logic [1:0]                                              htrans_i,
  input  logic [2:0]                                              hsize_i,
  output logic                                                    hresp_o,
  output logic                                                    hready_o,
  output logic [AHB_LITE_DATA_WIDTH-1:0]                          hrdata_o,
  input  logic [NUM_RESPONDERS-1:0]                               hresp_i,
  input  logic [NUM_RESPONDERS-1:0][AHB_LITE_DATA_WIDTH-1:0]      hrdata_i,
  input  logic [NUM_RESPONDERS-1:0]                               hreadyout_i,
  output logic [NUM_RESPONDERS-1:0][AHB_LITE_ADDR_WIDTH-1:0]      haddr_o,
  output logic [NUM_RESPONDERS-1:0][AHB_LITE_DATA_WIDTH-1:0]      hwdata_o,
  output logic [NUM_RESPONDERS-1:0]                               hwrite_o,
  output logic [NUM_RESPONDERS-1:0][1:0]                          htrans_o,
  output logic [NUM_RESPONDERS-1:0][2:0]                          hsize_o,
  output logic [NUM_RESPONDERS-1:0]                               hsel_o,
  output logic [NUM_RESPONDERS-1:0]                               hresponderready_o,
  input  logic [NUM_RESPONDERS-1:0][AHB_LITE_ADDR_WIDTH-1:0]      responder_start_addr_i,
  input  logic [NUM_RESPONDERS-1:0][AHB_LITE_ADDR_WIDTH-1:0]      responder_end_addr_i,
  input  logic [NUM_RESPONDERS-1:0]                               responder_wr_protect_i,
  input  logic [NUM_RESPONDERS-1:0]                               responder_disable_i,
  input  logic                                                    force_bus_idle,
  input  logic [TIMEOUT_WIDTH-1:0]                                timeout_cycles_i,
  output logic [NUM_RESPONDERS-1:0]                               access_blocked_o,
  output logic                                                    timeout_o,
  output logic [NUM_RESPONDERS-1:0]                               hung_o
);

  localparam int IDX_W = (NUM_RESPONDERS > 1) ? $clog2(NUM_RESPONDERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                     state_r;
  logic [NUM_RESPONDERS-1:0]  pend_sel_r;
  logic [TIMEOUT_WIDTH-1:0]   stall_cnt_r;
  logic [NUM_RESPONDERS-1:0]  hung_r;
  logic [NUM_RESPONDERS-1:0]  access_blocked_r;
  logic                       timeout_r;

  logic [NUM_RESPONDERS-1:0]  hit_vec_s;
  logic                       hit_any_s;
  logic [IDX_W-1:0]           hit_idx_s;
  logic [NUM_RESPONDERS-1:0]  hit_sel_s;
  logic                       refused_s;
  logic                       accept_s;
  logic                       good_sel_s;
  logic [IDX_W-1:0]           pend_idx_s;
  logic                       pend_ok_s;
  logic                       fire_s;
  logic                       hready_s;
  logic                       hresp_s;
  logic [AHB_LITE_DATA_WIDTH-1:0] hrdata_s;

  // Inclusive region match for every responder
  always_comb begin
    hit_vec_s = '0;
    for (int r = 0; r < NUM_RESPONDERS; r++) begin
      hit_vec_s[r] = !force_bus_idle &&
                     (haddr_i >= responder_start_addr_i[r]) &&
                     (haddr_i <= responder_end_addr_i[r]);
    end
  end

  // Lowest-index priority among overlapping regions
  always_comb begin
    hit_idx_s = '0;
    for (int r = NUM_RESPONDERS - 1; r >= 0; r--) begin
      hit_idx_s = hit_vec_s[r] ? IDX_W'(r) : hit_idx_s;
    end
  end

  assign hit_any_s  = |hit_vec_s;
  assign hit_sel_s  = hit_any_s ? (NUM_RESPONDERS'(1) << hit_idx_s) : '0;
  assign refused_s  = hit_any_s &&
                      (responder_disable_i[hit_idx_s] || hung_r[hit_idx_s] ||
                       (responder_wr_protect_i[hit_idx_s] && hwrite_i));
  assign hsel_o     = refused_s ? '0 : hit_sel_s;
  assign good_sel_s = hit_any_s && !refused_s;
  assign accept_s   = hready_s && htrans_i[1];

  // Index of the responder owning the current data phase
  always_comb begin
    pend_idx_s = '0;
    for (int r = NUM_RESPONDERS - 1; r >= 0; r--) begin
      pend_idx_s = pend_sel_r[r] ? IDX_W'(r) : pend_idx_s;
    end
  end

  assign pend_ok_s = |(pend_sel_r & ~hung_r);
  // Watchdog is decided from the count alone, so a late ready in the firing cycle is ignored
  assign fire_s    = (state_r == ST_DATA) && (timeout_cycles_i != '0) &&
                     (stall_cnt_r >= timeout_cycles_i);

  // Initiator-facing response for the current state
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    hrdata_s = '0;
    case (state_r)
      ST_IDLE: begin
        hready_s = 1'b1;
      end
      ST_DATA: begin
        if (fire_s || !pend_ok_s) begin
          hready_s = 1'b0;
        end else begin
          hready_s = hreadyout_i[pend_idx_s];
          hresp_s  = hresp_i[pend_idx_s];
          hrdata_s = hrdata_i[pend_idx_s];
        end
      end
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = 1'b1;
      end
      ST_ERR2: begin
        hready_s = 1'b1;
        hresp_s  = 1'b1;
      end
      default: begin
        hready_s = 1'b1;
      end
    endcase
  end

  // Data-phase FSM, stall counter, quarantine flags and event pulses
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r          <= ST_IDLE;
      pend_sel_r       <= '0;
      stall_cnt_r      <= '0;
      hung_r           <= '0;
      access_blocked_r <= '0;
      timeout_r        <= 1'b0;
    end else begin
      timeout_r        <= 1'b0;
      access_blocked_r <= (accept_s && refused_s) ? hit_sel_s : '0;
      case (state_r)
        ST_DATA: begin
          if (fire_s) begin
            state_r    <= ST_ERR1;
            pend_sel_r <= '0;
            hung_r     <= hung_r | pend_sel_r;
            timeout_r  <= 1'b1;
          end else if (!hready_s) begin
            if (stall_cnt_r != '1) begin
              stall_cnt_r <= stall_cnt_r + TIMEOUT_WIDTH'(1);
            end
          end else if (accept_s && good_sel_s) begin
            state_r     <= ST_DATA;
            pend_sel_r  <= hit_sel_s;
            stall_cnt_r <= '0;
          end else if (accept_s) begin
            state_r    <= ST_ERR1;
            pend_sel_r <= '0;
          end else begin
            state_r    <= ST_IDLE;
            pend_sel_r <= '0;
          end
        end
        ST_ERR1: begin
          state_r <= ST_ERR2;
        end
        ST_IDLE, ST_ERR2: begin
          if (accept_s && good_sel_s) begin
            state_r     <= ST_DATA;
            pend_sel_r  <= hit_sel_s;
            stall_cnt_r <= '0;
          end else if (accept_s) begin
            state_r    <= ST_ERR1;
            pend_sel_r <= '0;
          end else begin
            state_r    <= ST_IDLE;
            pend_sel_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pend_sel_r <= '0;
        end
      endcase
    end
  end

  // Address-phase broadcast to every responder
  always_comb begin
    for (int r = 0; r < NUM_RESPONDERS; r++) begin
      haddr_o[r]  = haddr_i;
      hwdata_o[r] = hwdata_i;
      hwrite_o[r] = hwrite_i;
      htrans_o[r] = htrans_i;
      hsize_o[r]  = hsize_i;
    end
  end

  assign hready_o          = hready_s;
  assign hresp_o           = hresp_s;
  assign hrdata_o          = hrdata_s;
  assign hresponderready_o = {NUM_RESPONDERS{hready_s}};
  assign access_blocked_o  = access_blocked_r;
  assign timeout_o         = timeout_r;
  assign hung_o            = hung_r;

endmodule

// File: tb/tb_ahb_lite_decoder_tmo.sv
// Randomized scoreboard bench for ahb_lite_decoder_tmo: a driver issues transfers and queues the
// expected data-phase outcome; a negedge monitor pops and compares.
module tb_ahb_lite_decoder_tmo;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic              hclk = 1'b0;
  logic              hreset;
  logic [31:0]       haddr_i, hwdata_i, hrdata_o;
  logic              hwrite_i, hresp_o, hready_o, force_bus_idle, timeout_o, g_ready;
  logic [1:0]        htrans_i;
  logic [2:0]        hsize_i;
  logic [7:0]        hresp_i, hreadyout_i, hwrite_o, hsel_o, hresponderready_o;
  logic [7:0]        wp_p, dis_p, access_blocked_o, hung_o, model_hung;
  logic [7:0][31:0]  rd_val, haddr_o, hwdata_o, rs_p, re_p;
  logic [7:0][1:0]   htrans_o;
  logic [7:0][2:0]   hsize_o;
  logic [15:0]       tmo_cycles;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          low;
    logic [7:0]  blocked;
    bit          tmo;
    logic [7:0]  hung_after;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   mon_low = 0;
  int   total = 0;
  int   bad = 0;
  int   prev_waits = 0;

  assign hreadyout_i = {8{g_ready}};

  ahb_lite_decoder_tmo dut (
    .hclk(hclk), .hreset(hreset),
    .haddr_i(haddr_i), .hwdata_i(hwdata_i), .hwrite_i(hwrite_i), .htrans_i(htrans_i), .hsize_i(hsize_i),
    .hresp_o(hresp_o), .hready_o(hready_o), .hrdata_o(hrdata_o),
    .hresp_i(hresp_i), .hrdata_i(rd_val), .hreadyout_i(hreadyout_i),
    .haddr_o(haddr_o), .hwdata_o(hwdata_o), .hwrite_o(hwrite_o), .htrans_o(htrans_o), .hsize_o(hsize_o),
    .hsel_o(hsel_o), .hresponderready_o(hresponderready_o),
    .responder_start_addr_i(rs_p), .responder_end_addr_i(re_p),
    .responder_wr_protect_i(wp_p), .responder_disable_i(dis_p),
    .force_bus_idle(force_bus_idle), .timeout_cycles_i(tmo_cycles),
    .access_blocked_o(access_blocked_o), .timeout_o(timeout_o), .hung_o(hung_o)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: first region (lowest index) containing the address; kind 0=none 1=ok 2=refused
  function automatic void model_decode(input logic [31:0] a, input logic wr, output int idx, output int kind);
    idx  = -1;
    kind = 0;
    if (!force_bus_idle) begin
      for (int r = 0; r < 8; r++) begin
        if (idx < 0 && a >= rs_p[r] && a <= re_p[r]) idx = r;
      end
    end
    if (idx >= 0) kind = (dis_p[idx] || model_hung[idx] || (wp_p[idx] && wr)) ? 2 : 1;
  endfunction

  // Present one address phase, hold it until accepted, and queue its expected outcome
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [1:0] trans, input int waits);
    int c;
    int idx;
    int kind;
    bit got;
    exp_t e;
    logic [7:0] exp_sel;
    haddr_i  = addr;
    hwrite_i = wr;
    htrans_i = trans;
    hwdata_i = $urandom;
    hsize_i  = 3'($urandom_range(0, 2));
    c = 0;
    got = 1'b0;
    g_ready = (prev_waits == 0);
    while (!got && c <= 300) begin
      @(negedge hclk);
      if (hready_o === 1'b1) begin
        got = 1'b1;
      end else begin
        @(posedge hclk);
        #1;
        c++;
        g_ready = (c >= prev_waits);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL hready_wait actual=stuck required=ready_within_300_cycles");
    end else begin
      model_decode(addr, wr, idx, kind);
      exp_sel = (kind == 1) ? (8'd1 << idx) : 8'h00;
      chk("hsel", hsel_o, exp_sel);
      chk("bcast_addr", haddr_o[5], addr);
      chk("resp_ready_copy", hresponderready_o, 8'hFF);
      @(posedge hclk);
      if (trans[1]) begin
        e.tmo = 1'b0;
        e.blocked = 8'h00;
        if (kind == 1 && tmo_cycles != 16'd0 && waits >= tmo_cycles) begin
          e.resp = 1'b1; e.rdata = 32'h0; e.low = tmo_cycles + 2; e.tmo = 1'b1;
          model_hung[idx] = 1'b1;
        end else if (kind == 1) begin
          e.resp = hresp_i[idx]; e.rdata = rd_val[idx]; e.low = waits;
        end else begin
          e.resp = 1'b1; e.rdata = 32'h0; e.low = 1;
          if (kind == 2) e.blocked = 8'd1 << idx;
        end
        e.hung_after = model_hung;
        q.push_back(e);
      end
      #1;
      prev_waits = (trans[1] && kind == 1) ? waits : 0;
    end
  endtask

  task automatic do_reset();
    hreset   = 1'b1;
    htrans_i = T_IDLE;
    g_ready  = 1'b1;
    @(posedge hclk);
    #1;
    hreset     = 1'b0;
    q.delete();
    model_hung = 8'h00;
    prev_waits = 0;
  endtask

  // Monitor: compare the presented response with the head of the expected queue
  always @(negedge hclk) begin
    if (hreset === 1'b1) begin
      mon_low = 0;
    end else if (q.size() == 0) begin
      chk("idle_rdy_resp_tmo_blk_hung_rdata",
          {hready_o, hresp_o, timeout_o, access_blocked_o, hung_o, hrdata_o},
          {1'b1, 1'b0, 1'b0, 8'h00, model_hung, 32'h0});
      mon_low = 0;
    end else begin
      mon_e = q[0];
      if (mon_low == 0) chk("access_blocked", access_blocked_o, mon_e.blocked);
      chk("timeout_pulse", timeout_o, (mon_e.tmo && mon_low == mon_e.low - 1));
      if (hready_o === 1'b1) begin
        chk("wait_cycles", mon_low, mon_e.low);
        chk("hresp", hresp_o, mon_e.resp);
        chk("hrdata", hrdata_o, mon_e.rdata);
        chk("hung", hung_o, mon_e.hung_after);
        void'(q.pop_front());
        mon_low = 0;
      end else begin
        mon_low++;
        if (mon_low > 400) begin
          chk("data_phase_bound", 64'(mon_low), 64'd400);
          void'(q.pop_front());
          mon_low = 0;
        end
      end
    end
  end

  initial begin
    int sel;
    int pick;
    logic [31:0] a;
    logic [1:0] tr;
    hreset = 1'b1; haddr_i = '0; hwdata_i = '0; hwrite_i = 1'b0; htrans_i = T_IDLE; hsize_i = 3'd2;
    force_bus_idle = 1'b0; g_ready = 1'b1; tmo_cycles = 16'd0; wp_p = 8'h00; dis_p = 8'h00;
    hresp_i = 8'h40; model_hung = 8'h00;
    rs_p[0] = 32'h0000_3800; re_p[0] = 32'h0000_8FFF;
    for (int r = 1; r < 8; r++) begin
      rs_p[r] = 32'((r - 1) * 32'h1000);
      re_p[r] = rs_p[r] + 32'h0FFF;
    end
    for (int r = 0; r < 8; r++) rd_val[r] = $urandom;
    repeat (2) @(posedge hclk);
    #1;
    do_reset();

    issue(32'h0000_1000, 1'b0, T_NSEQ, 0);
    issue(32'hFFFF_0000, 1'b0, T_NSEQ, 0);
    wp_p = 8'h02;
    issue(32'h0000_0100, 1'b1, T_NSEQ, 0);
    issue(32'h0000_0100, 1'b0, T_NSEQ, 1);
    tmo_cycles = 16'd5;
    issue(32'h0000_2010, 1'b0, T_NSEQ, 20);
    issue(32'h0000_2020, 1'b0, T_SEQ, 0);
    issue(32'h0000_4000, 1'b0, T_NSEQ, 50);
    htrans_i = T_IDLE;
    g_ready  = 1'b0;
    repeat (3) begin
      @(posedge hclk);
      #1;
    end
    do_reset();
    issue(32'h0000_2000, 1'b0, T_NSEQ, 1);
    issue(32'h0000_3900, 1'b0, T_NSEQ, 0);
    issue(32'hFFFF_0000, 1'b0, T_BUSY, 0);
    issue(32'hFFFF_0000, 1'b1, T_IDLE, 0);
    issue(32'h0000_3900, 1'b1, T_NSEQ, 2);
    issue(32'h0000_0000, 1'b0, T_IDLE, 0);
    @(posedge hclk);
    #1;

    for (int b = 0; b < 4; b++) begin
      do_reset();
      pick = $urandom_range(0, 2);
      tmo_cycles = 16'(pick * 2);
      dis_p = 8'($urandom & $urandom & $urandom);
      wp_p  = 8'($urandom & $urandom);
      hresp_i = 8'($urandom & $urandom & $urandom);
      for (int r = 0; r < 8; r++) rd_val[r] = $urandom;
      for (int k = 0; k < 40; k++) begin
        sel = $urandom_range(0, 9);
        if (sel >= 8) a = 32'h0001_0000 + 32'($urandom_range(0, 32'hFFFF));
        else a = rs_p[sel] + 32'($urandom_range(0, 32'h0FFF));
        pick = $urandom_range(0, 7);
        tr = (pick == 0) ? T_IDLE : (pick == 1) ? T_BUSY : (pick < 5) ? T_NSEQ : T_SEQ;
        force_bus_idle = ($urandom_range(0, 15) == 0);
        issue(a, 1'($urandom_range(0, 1)), tr, $urandom_range(0, 5));
      end
      force_bus_idle = 1'b0;
      issue(32'h0000_0000, 1'b0, T_IDLE, 0);
      @(posedge hclk);
      #1;
    end
    repeat (2) @(posedge hclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
